// File: rtl/rv_ctrl_pkg.sv
// rtl/rv_ctrl_pkg.sv - shared opcode, state and datapath mux-select encodings
package rv_ctrl_pkg;

    localparam int STATE_W = 4;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_EXEC_I   = 4'd4,
        S_ALU_WB   = 4'd5,
        S_MEM_ADDR = 4'd6,
        S_MEM_RD   = 4'd7,
        S_MEM_WB   = 4'd8,
        S_MEM_WR   = 4'd9,
        S_BRANCH   = 4'd10,
        S_JAL      = 4'd11,
        S_JALR     = 4'd12,
        S_TRAP     = 4'd13
    } state_t;

    typedef enum logic [2:0] {
        CLS_EXEC_R = 3'd0,
        CLS_EXEC_I = 3'd1,
        CLS_MEM    = 3'd2,
        CLS_BRANCH = 3'd3,
        CLS_JAL    = 3'd4,
        CLS_JALR   = 3'd5,
        CLS_TRAP   = 3'd6
    } op_class_t;

    localparam logic [1:0] ALU_A_PC    = 2'b00;
    localparam logic [1:0] ALU_A_OLDPC = 2'b01;
    localparam logic [1:0] ALU_A_RS1   = 2'b10;
    localparam logic [1:0] ALU_A_ZERO  = 2'b11;

    localparam logic [1:0] ALU_B_RS2   = 2'b00;
    localparam logic [1:0] ALU_B_IMM   = 2'b01;
    localparam logic [1:0] ALU_B_FOUR  = 2'b10;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

    localparam logic [1:0] WB_ALUOUT = 2'b00;
    localparam logic [1:0] WB_MEM    = 2'b01;
    localparam logic [1:0] WB_PC     = 2'b10;

endpackage

// File: rtl/mc_opcode_decode.sv
// rtl/mc_opcode_decode.sv - opcode to instruction class and flavour flags
module mc_opcode_decode
    import rv_ctrl_pkg::*;
(
    input  logic [6:0] i_opcode,
    output op_class_t  o_class,
    output logic       o_is_load,
    output logic       o_is_lui,
    output logic       o_is_auipc,
    output logic       o_illegal
);

    always_comb begin
        o_class    = CLS_TRAP;
        o_is_load  = 1'b0;
        o_is_lui   = 1'b0;
        o_is_auipc = 1'b0;
        o_illegal  = 1'b0;
        case (i_opcode)
            OP_R:      o_class = CLS_EXEC_R;
            OP_IMM:    o_class = CLS_EXEC_I;
            OP_LUI: begin
                o_class  = CLS_EXEC_I;
                o_is_lui = 1'b1;
            end
            OP_AUIPC: begin
                o_class    = CLS_EXEC_I;
                o_is_auipc = 1'b1;
            end
            OP_LOAD: begin
                o_class   = CLS_MEM;
                o_is_load = 1'b1;
            end
            OP_STORE:  o_class = CLS_MEM;
            OP_BRANCH: o_class = CLS_BRANCH;
            OP_JAL:    o_class = CLS_JAL;
            OP_JALR:   o_class = CLS_JALR;
            default:   o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// rtl/multicycle_ctrl_fsm.sv - multicycle RV32I control FSM driving datapath mux selects and memory port
module multicycle_ctrl_fsm
    import rv_ctrl_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic [6:0] opcode,
    input  logic       br_cond,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       addr_sel,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_src_sel,
    output logic [1:0] alu_a_sel,
    output logic [1:0] alu_b_sel,
    output logic [1:0] alu_op,
    output logic [1:0] wb_sel,
    output logic       reg_write,
    output logic       retire,
    output logic       illegal_instr,
    output logic       busy
);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_next;
    logic [STATE_W-1:0] w_after_retire;
    logic               r_illegal;
    op_class_t          w_class;
    logic               w_is_load;
    logic               w_is_lui;
    logic               w_is_auipc;
    logic               w_illegal;

    mc_opcode_decode u_decode (
        .i_opcode   (opcode),
        .o_class    (w_class),
        .o_is_load  (w_is_load),
        .o_is_lui   (w_is_lui),
        .o_is_auipc (w_is_auipc),
        .o_illegal  (w_illegal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE && w_illegal)
                r_illegal <= 1'b1;
        end
    end

    // run is only honoured at instruction boundaries, never mid-instruction
    assign w_after_retire = run ? S_FETCH : S_IDLE;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (run) w_next = S_FETCH;
            S_FETCH:    if (mem_ready) w_next = S_DECODE;
            S_DECODE: begin
                case (w_class)
                    CLS_EXEC_R: w_next = S_EXEC_R;
                    CLS_EXEC_I: w_next = S_EXEC_I;
                    CLS_MEM:    w_next = S_MEM_ADDR;
                    CLS_BRANCH: w_next = S_BRANCH;
                    CLS_JAL:    w_next = S_JAL;
                    CLS_JALR:   w_next = S_JALR;
                    default:    w_next = S_TRAP;
                endcase
            end
            S_EXEC_R:   w_next = S_ALU_WB;
            S_EXEC_I:   w_next = S_ALU_WB;
            S_MEM_ADDR: w_next = w_is_load ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (mem_ready) w_next = S_MEM_WB;
            S_MEM_WR:   if (mem_ready) w_next = w_after_retire;
            S_ALU_WB, S_MEM_WB, S_BRANCH, S_JAL, S_JALR:
                        w_next = w_after_retire;
            S_TRAP:     w_next = S_TRAP;
            default:    w_next = S_IDLE;
        endcase
    end

    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        addr_sel   = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src_sel = 1'b0;
        alu_a_sel  = ALU_A_PC;
        alu_b_sel  = ALU_B_RS2;
        alu_op     = ALUOP_ADD;
        wb_sel     = WB_ALUOUT;
        reg_write  = 1'b0;
        retire     = 1'b0;
        busy       = 1'b1;
        case (r_state)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_b_sel = ALU_B_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_a_sel = ALU_A_OLDPC;
                alu_b_sel = ALU_B_IMM;
            end
            S_EXEC_R: begin
                alu_a_sel = ALU_A_RS1;
                alu_op    = ALUOP_FUNCT;
            end
            S_EXEC_I: begin
                alu_a_sel = w_is_lui   ? ALU_A_ZERO  :
                            w_is_auipc ? ALU_A_OLDPC : ALU_A_RS1;
                alu_b_sel = ALU_B_IMM;
                alu_op    = ALUOP_FUNCT;
            end
            S_ALU_WB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            S_MEM_ADDR: begin
                alu_a_sel = ALU_A_RS1;
                alu_b_sel = ALU_B_IMM;
            end
            S_MEM_RD: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
            end
            S_MEM_WB: begin
                wb_sel    = WB_MEM;
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            S_MEM_WR: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                addr_sel = 1'b1;
                retire   = mem_ready;
            end
            S_BRANCH: begin
                alu_a_sel  = ALU_A_RS1;
                alu_op     = ALUOP_BRANCH;
                pc_src_sel = 1'b1;
                pc_write   = br_cond;
                retire     = 1'b1;
            end
            S_JAL: begin
                wb_sel     = WB_PC;
                reg_write  = 1'b1;
                pc_src_sel = 1'b1;
                pc_write   = 1'b1;
                retire     = 1'b1;
            end
            S_JALR: begin
                alu_a_sel = ALU_A_RS1;
                alu_b_sel = ALU_B_IMM;
                pc_write  = 1'b1;
                wb_sel    = WB_PC;
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            default: busy = 1'b0;
        endcase
    end

    assign illegal_instr = r_illegal;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb/tb_multicycle_ctrl_fsm.sv - directed scoreboard bench for multicycle_ctrl_fsm
module tb_multicycle_ctrl_fsm;

    logic       clk;
    logic       rst_n;
    logic       run;
    logic [6:0] opcode;
    logic       br_cond;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_we;
    logic       addr_sel;
    logic       ir_write;
    logic       pc_write;
    logic       pc_src_sel;
    logic [1:0] alu_a_sel;
    logic [1:0] alu_b_sel;
    logic [1:0] alu_op;
    logic [1:0] wb_sel;
    logic       reg_write;
    logic       retire;
    logic       illegal_instr;
    logic       busy;

    int n_assert;
    int n_fail;
    logic [17:0] exp_q[$];

    multicycle_ctrl_fsm #(.STATE_W(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .run           (run),
        .opcode        (opcode),
        .br_cond       (br_cond),
        .mem_ready     (mem_ready),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .addr_sel      (addr_sel),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .pc_src_sel    (pc_src_sel),
        .alu_a_sel     (alu_a_sel),
        .alu_b_sel     (alu_b_sel),
        .alu_op        (alu_op),
        .wb_sel        (wb_sel),
        .reg_write     (reg_write),
        .retire        (retire),
        .illegal_instr (illegal_instr),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [6:0] ADD_OP  = 7'b0110011;
    localparam logic [6:0] LW_OP   = 7'b0000011;
    localparam logic [6:0] SW_OP   = 7'b0100011;
    localparam logic [6:0] BEQ_OP  = 7'b1100011;
    localparam logic [6:0] JAL_OP  = 7'b1101111;
    localparam logic [6:0] JALR_OP = 7'b1100111;
    localparam logic [6:0] LUI_OP  = 7'b0110111;
    localparam logic [6:0] AUI_OP  = 7'b0010111;
    localparam logic [6:0] ADDI_OP = 7'b0010011;

    // {mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src, a, b, op, wb, reg_write, retire, illegal, busy}
    function automatic logic [17:0] v(input logic mq, input logic we, input logic as_,
                                      input logic irw, input logic pcw, input logic pcs,
                                      input logic [1:0] a, input logic [1:0] b,
                                      input logic [1:0] op, input logic [1:0] wb,
                                      input logic rw, input logic rt, input logic il,
                                      input logic bz);
        return {mq, we, as_, irw, pcw, pcs, a, b, op, wb, rw, rt, il, bz};
    endfunction

    function automatic logic [17:0] e_idle();
        return 18'd0;
    endfunction
    function automatic logic [17:0] e_fetch(input logic rdy);
        return v(1, 0, 0, rdy, rdy, 0, 2'b00, 2'b10, 2'b00, 2'b00, 0, 0, 0, 1);
    endfunction
    function automatic logic [17:0] e_decode();
        return v(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 2'b00, 0, 0, 0, 1);
    endfunction
    function automatic logic [17:0] e_exec_r();
        return v(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0, 0, 1);
    endfunction
    function automatic logic [17:0] e_exec_i(input logic [1:0] a);
        return v(0, 0, 0, 0, 0, 0, a, 2'b01, 2'b10, 2'b00, 0, 0, 0, 1);
    endfunction
    function automatic logic [17:0] e_alu_wb();
        return v(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 1, 0, 1);
    endfunction
    function automatic logic [17:0] e_mem_addr();
        return v(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b00, 0, 0, 0, 1);
    endfunction
    function automatic logic [17:0] e_mem_rd();
        return v(1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 1);
    endfunction
    function automatic logic [17:0] e_mem_wb();
        return v(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b01, 1, 1, 0, 1);
    endfunction
    function automatic logic [17:0] e_mem_wr(input logic rdy);
        return v(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, rdy, 0, 1);
    endfunction
    function automatic logic [17:0] e_branch(input logic c);
        return v(0, 0, 0, 0, c, 1, 2'b10, 2'b00, 2'b01, 2'b00, 0, 1, 0, 1);
    endfunction
    function automatic logic [17:0] e_jal();
        return v(0, 0, 0, 0, 1, 1, 2'b00, 2'b00, 2'b00, 2'b10, 1, 1, 0, 1);
    endfunction
    function automatic logic [17:0] e_jalr();
        return v(0, 0, 0, 0, 1, 0, 2'b10, 2'b01, 2'b00, 2'b10, 1, 1, 0, 1);
    endfunction
    function automatic logic [17:0] e_trap();
        return v(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 1, 0);
    endfunction

    task automatic check_now(input string tag);
        logic [17:0] obs;
        logic [17:0] exp;
        obs = {mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src_sel, alu_a_sel,
               alu_b_sel, alu_op, wb_sel, reg_write, retire, illegal_instr, busy};
        exp = exp_q.pop_front();
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Drive inputs just after a rising edge, sample on the falling edge, then advance
    task automatic step(input string tag, input logic r, input logic rdy,
                        input logic bc, input logic [6:0] op, input logic [17:0] e);
        run       = r;
        mem_ready = rdy;
        br_cond   = bc;
        opcode    = op;
        exp_q.push_back(e);
        @(negedge clk);
        check_now(tag);
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_assert  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        run       = 1'b0;
        opcode    = 7'd0;
        br_cond   = 1'b0;
        mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back(e_idle());
        check_now("reset_state");
        rst_n = 1'b1;

        step("idle_run", 1, 0, 0, ADD_OP, e_idle());
        step("add_fetch", 1, 1, 0, ADD_OP, e_fetch(1));
        step("add_decode", 1, 1, 0, ADD_OP, e_decode());
        step("add_exec_r", 1, 1, 0, ADD_OP, e_exec_r());
        step("add_alu_wb", 1, 1, 0, ADD_OP, e_alu_wb());

        for (int i = 0; i < 3; i++) step("lw_fetch_wait", 1, 0, 0, LW_OP, e_fetch(0));
        step("lw_fetch_done", 1, 1, 0, LW_OP, e_fetch(1));
        step("lw_decode", 1, 0, 0, LW_OP, e_decode());
        step("lw_mem_addr", 1, 1, 0, LW_OP, e_mem_addr());
        for (int i = 0; i < 3; i++) step("lw_rd_wait", 1, 0, 0, LW_OP, e_mem_rd());
        step("lw_rd_done", 1, 1, 0, LW_OP, e_mem_rd());
        step("lw_mem_wb", 1, 0, 0, LW_OP, e_mem_wb());

        step("beq_t_fetch", 1, 1, 1, BEQ_OP, e_fetch(1));
        step("beq_t_decode", 1, 1, 1, BEQ_OP, e_decode());
        step("beq_taken", 1, 1, 1, BEQ_OP, e_branch(1));
        step("beq_n_fetch", 1, 1, 0, BEQ_OP, e_fetch(1));
        step("beq_n_decode", 1, 1, 0, BEQ_OP, e_decode());
        step("beq_not_taken", 1, 1, 0, BEQ_OP, e_branch(0));

        step("jalr_fetch", 1, 1, 0, JALR_OP, e_fetch(1));
        step("jalr_decode", 1, 1, 0, JALR_OP, e_decode());
        step("jalr_exec", 1, 1, 0, JALR_OP, e_jalr());

        step("jal_fetch", 1, 1, 0, JAL_OP, e_fetch(1));
        step("jal_decode", 1, 1, 0, JAL_OP, e_decode());
        step("jal_exec", 1, 1, 0, JAL_OP, e_jal());

        step("lui_fetch", 1, 1, 0, LUI_OP, e_fetch(1));
        step("lui_decode", 1, 1, 0, LUI_OP, e_decode());
        step("lui_exec_i", 1, 1, 0, LUI_OP, e_exec_i(2'b11));
        step("lui_alu_wb", 1, 1, 0, LUI_OP, e_alu_wb());
        step("auipc_fetch", 1, 1, 0, AUI_OP, e_fetch(1));
        step("auipc_decode", 1, 1, 0, AUI_OP, e_decode());
        step("auipc_exec_i", 1, 1, 0, AUI_OP, e_exec_i(2'b01));
        step("auipc_alu_wb", 1, 1, 0, AUI_OP, e_alu_wb());
        step("addi_fetch", 1, 1, 0, ADDI_OP, e_fetch(1));
        step("addi_decode", 1, 1, 0, ADDI_OP, e_decode());
        step("addi_exec_i", 1, 1, 0, ADDI_OP, e_exec_i(2'b10));
        step("addi_alu_wb", 0, 1, 0, ADDI_OP, e_alu_wb());

        // run dropped at the retire above: back to IDLE, mem_ready ignored there
        step("stop_idle", 0, 1, 0, SW_OP, e_idle());
        step("stop_idle2", 1, 1, 0, SW_OP, e_idle());

        // Store with run dropped mid-instruction still completes and retires
        step("sw_fetch", 0, 1, 0, SW_OP, e_fetch(1));
        step("sw_decode", 0, 1, 0, SW_OP, e_decode());
        step("sw_mem_addr", 0, 0, 0, SW_OP, e_mem_addr());
        step("sw_wr_wait", 0, 0, 0, SW_OP, e_mem_wr(0));
        step("sw_wr_done", 0, 1, 0, SW_OP, e_mem_wr(1));
        step("sw_then_idle", 0, 1, 0, SW_OP, e_idle());
        step("sw_idle_hold", 1, 0, 0, SW_OP, e_idle());

        // Reset in the middle of a store wait
        step("sw2_fetch", 1, 1, 0, SW_OP, e_fetch(1));
        step("sw2_decode", 1, 1, 0, SW_OP, e_decode());
        step("sw2_mem_addr", 1, 0, 0, SW_OP, e_mem_addr());
        step("sw2_wr_wait", 1, 0, 0, SW_OP, e_mem_wr(0));
        exp_q.push_back(e_mem_wr(0));
        check_now("sw2_wr_wait2");
        rst_n = 1'b0;
        #1;
        exp_q.push_back(e_idle());
        check_now("async_reset_mem_wr");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step("post_reset_idle", 1, 0, 0, 7'd0, e_idle());

        step("ill_fetch", 1, 1, 0, 7'd0, e_fetch(1));
        step("ill_decode", 1, 1, 0, 7'd0, e_decode());
        for (int i = 0; i < 20; i++)
            step("trap_hold", 1, i[0], i[1], 7'd0, e_trap());
        rst_n = 1'b0;
        #1;
        exp_q.push_back(e_idle());
        check_now("trap_reset_clear");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step("trap_reset_idle", 0, 0, 0, ADD_OP, e_idle());
        step("trap_reset_idle2", 0, 0, 0, ADD_OP, e_idle());

        n_assert++;
        assert (exp_q.size() == 0) else begin
            n_fail++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
